// File: rtl/bka_multiword_sequencer_if.sv
// Operand/result handshake bundle for bka_multiword_sequencer; the ovf wire
// exists only when BKA_SEQ_OVF_EN is defined.
interface bka_multiword_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int N = 25 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   s;
`ifdef BKA_SEQ_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, s, ovf
  );
  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, s, ovf
  );
`else
  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, s
  );
  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, s
  );
`endif
endinterface

// File: rtl/bka_multiword_sequencer.sv
// Wide adder: one 25-bit Brent-Kung core reused LSB->MSB, result WORDS cycles after accept,
// held in DONE until out_ready (in_ready low while busy). BKA_SEQ_OVF_EN adds the ovf output.
module ubpri_bka_24_0 (
  input  logic [24:0] x,
  input  logic [24:0] y,
  input  logic        cin,
  output logic [25:0] s
);
  logic [24:0] p;
  logic [24:0] gg;
  logic [24:0] pp;

  always_comb begin
    p  = x ^ y;
    pp = p;
    gg = x & y;
    // Folding cin into bit 0 makes every gg[i] the carry out of bit i.
    gg[0] = gg[0] | (p[0] & cin);
    for (int lv = 0; lv < 4; lv++) begin
      for (int i = (2 << lv) - 1; i < 25; i += (2 << lv)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << lv)]);
        pp[i] = pp[i] & pp[i - (1 << lv)];
      end
    end
    for (int lv = 3; lv >= 0; lv--) begin
      for (int i = 3 * (1 << lv) - 1; i < 25; i += (2 << lv)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << lv)]);
        pp[i] = pp[i] & pp[i - (1 << lv)];
      end
    end
    s    = '0;
    s[0] = p[0] ^ cin;
    for (int i = 1; i < 25; i++) begin
      s[i] = p[i] ^ gg[i-1];
    end
    s[25] = gg[24];
  end
endmodule

module bka_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  bka_multiword_sequencer_if.slave bus
);
  localparam int N  = 25 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  xr_q, xr_d;
  logic [N-1:0]  yr_q, yr_d;
  logic [N:0]    sum_q, sum_d;
  logic          in_rdy, out_vld, accept, last_slice;
  logic [24:0]   x_sl, y_sl;
  logic [25:0]   core_s;
`ifdef BKA_SEQ_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshakes are masked during reset so nothing leaks out of the reset cycle.
  always_comb begin
    in_rdy  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    out_vld = !rst && (state_q == DONE);
    accept  = bus.in_valid && in_rdy;
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.s         = sum_q;
`ifdef BKA_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

  assign last_slice = (k_q == KW'(WORDS - 1));

  always_comb begin
    x_sl = '0;
    y_sl = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (k_q == KW'(w)) begin
        x_sl = xr_q[25*w +: 25];
        y_sl = yr_q[25*w +: 25];
      end
    end
  end

  ubpri_bka_24_0 u_core (
    .x   (x_sl),
    .y   (y_sl),
    .cin (carry_q),
    .s   (core_s)
  );

  always_comb begin
    k_d     = k_q;
    carry_d = carry_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    sum_d   = sum_q;
`ifdef BKA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      xr_d    = bus.x;
      yr_d    = bus.y;
      carry_d = bus.cin;
      k_d     = '0;
    end else if (state_q == BUSY) begin
      for (int w = 0; w < WORDS; w++) begin
        if (k_q == KW'(w)) sum_d[25*w +: 25] = core_s[24:0];
      end
      carry_d = core_s[25];
      k_d     = k_q + KW'(1);
      if (last_slice) begin
        sum_d[N] = core_s[25];
`ifdef BKA_SEQ_OVF_EN
        // core_s[24] is the new sum[N-1]; this yields carry-in xor carry-out of the MSB.
        ovf_d = xr_q[N-1] ^ yr_q[N-1] ^ core_s[24] ^ core_s[25];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      xr_q    <= '0;
      yr_q    <= '0;
      sum_q   <= '0;
`ifdef BKA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      k_q     <= k_d;
      carry_q <= carry_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      sum_q   <= sum_d;
`ifdef BKA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_bka_multiword_sequencer.sv
// Randomized scoreboard bench: expected sums from an arithmetic model are queued at
// accept and checked by an independent monitor whenever a result handshake occurs.
module tb_bka_multiword_sequencer;
  localparam int WORDS = 4;
  localparam int N     = 25 * WORDS;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   ordy_mode = 1;

  logic [N+1:0] exp_q[$];
  int           acc_q[$];
  logic         ov_prev = 1'b0;
  logic         held = 1'b0;
  logic [N:0]   held_s;

  bka_multiword_sequencer_if #(.WORDS(WORDS)) bus ();

  bka_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  function automatic void chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // {ovf, s}: exact unsigned sum and signed-range overflow of the N-bit result.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    logic [N:0] us;
    logic [N:0] ss;
    us = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    ss = {a[N-1], a} + {b[N-1], b} + {{N{1'b0}}, c};
    return {ss[N] ^ ss[N-1], us};
  endfunction

  function automatic logic [N-1:0] rv();
    logic [N-1:0] v;
    v = '0;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      default: for (int i = 0; i < (N + 31) / 32; i++) v = (v << 32) | N'($urandom);
    endcase
    return v;
  endfunction

  always begin
    @(posedge clk);
    #2;
    case (ordy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: records accepts, pops and compares on every result handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      ov_prev = 1'b0;
      held    = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.x, bus.y, bus.cin));
        acc_q.push_back(cyc + 1);
      end
      if (bus.out_valid) begin
        if (!ov_prev && acc_q.size() > 0)
          chk("latency", (N+1)'(cyc - acc_q.pop_front()), (N+1)'(WORDS));
        if (held) chk("hold_s", bus.s, held_s);
        if (bus.out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_result s=%h", bus.s);
          end else begin
            logic [N+1:0] e;
            e = exp_q.pop_front();
            chk("sum", bus.s, e[N:0]);
`ifdef BKA_SEQ_OVF_EN
            chk("ovf", (N+1)'(bus.ovf), (N+1)'(e[N+1]));
`endif
          end
        end else begin
          held   = 1'b1;
          held_s = bus.s;
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    int w;
    @(posedge clk);
    #1;
    bus.x = a;
    bus.y = b;
    bus.cin = c;
    bus.in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.in_ready && w < 200);
    if (!bus.in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x = rv();
    bus.y = rv();
    bus.cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", (N+1)'(exp_q.size()), '0);
  endtask

  initial begin
    logic [N-1:0] ones;
    logic [N:0]   hs;
    int           w;
    ones = '1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", (N+1)'(bus.in_ready), '0);
    chk("reset_out_valid", (N+1)'(bus.out_valid), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", (N+1)'(bus.in_ready), (N+1)'(1));
    chk("post_reset_out_valid", (N+1)'(bus.out_valid), '0);
    chk("post_reset_s", bus.s, '0);
`ifdef BKA_SEQ_OVF_EN
    chk("post_reset_ovf", (N+1)'(bus.ovf), '0);
`endif

    // Full ripple, then carry-in-only cases.
    do_op(ones, {{(N-1){1'b0}}, 1'b1}, 1'b0);
    do_op('0, '0, 1'b1);
    do_op(ones, ones, 1'b1);
    drain();

    // Back-pressure in DONE, then simultaneous result/operand handshakes.
    ordy_mode = 0;
    do_op(rv(), rv(), 1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.out_valid && w < 50);
    chk("bp_out_valid_rise", (N+1)'(bus.out_valid), (N+1)'(1));
    hs = bus.s;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", (N+1)'(bus.out_valid), (N+1)'(1));
      chk("bp_in_ready", (N+1)'(bus.in_ready), '0);
      chk("bp_s_stable", bus.s, hs);
    end
    @(posedge clk);
    #1;
    bus.x = rv();
    bus.y = rv();
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    ordy_mode = 1;
    @(negedge clk);
    chk("overlap_in_ready", (N+1)'(bus.in_ready), (N+1)'(1));
    chk("overlap_out_valid", (N+1)'(bus.out_valid), (N+1)'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    // Reset during BUSY aborts the operation; in_valid is ignored while busy.
    do_op(N'(5), N'(7), 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("busy_in_ready", (N+1)'(bus.in_ready), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", (N+1)'(bus.out_valid), '0);
    chk("abort_s", bus.s, '0);
    chk("abort_in_ready", (N+1)'(bus.in_ready), (N+1)'(1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_result", (N+1)'(bus.out_valid), '0);
    end

    // Signed overflow into the MSB, then the wrap-to-zero case without overflow.
    do_op(ones >> 1, {{(N-1){1'b0}}, 1'b1}, 1'b0);
    do_op(ones, {{(N-1){1'b0}}, 1'b1}, 1'b0);
    drain();

    ordy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(rv(), rv(), 1'($urandom_range(0, 1)));
    end
    ordy_mode = 1;
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
